pipe_control: RTL and testbench

PIPE_CONTROL -- requirements
Module: pipe_control

---
 rtl/pipe_control.sv | 158 +++++++++++++++
 tb/tb_pipe_control.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_control.sv
// rtl/pipe_control.sv - EX-stage decode, branch flush sequencer and MEM/WB control pipeline
//
// Optional feature macro: PIPE_PERF_COUNTER_EN (retired-instruction counter).
//
// Ports:
//   clk            in   1   rising-edge clock
//   reset          in   1   synchronous active-high reset
//   current_opcode in   7   opcode of the instruction in ID/EX
//   current_func   in   4   {instr[30], instr[14:12]} of the instruction in ID/EX
//   branch_taken   in   1   EX/MEM branch resolution, one-cycle pulse
//   stall          in   1   freezes flush sequencer, inserts a MEM bubble
//   branch_inst    out  1   EX: conditional branch
//   reg_reg_inst   out  1   EX: second ALU operand from register file
//   ex_load_inst   out  1   EX: memory access (load or store)
//   ex_reg_dest    out  1   EX: store destination select
//   alu_op         out  4   EX: ALU operation
//   load_inst      out  1   MEM: registered ex_load_inst
//   reg_dest       out  1   MEM: registered ex_reg_dest
//   illegal_inst   out  1   EX: unrecognised opcode
//   retired_count  out 32   valid instructions leaving WB (0 when counter disabled)
module pipe_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  current_opcode,
    input  logic [3:0]  current_func,
    input  logic        branch_taken,
    input  logic        stall,
    output logic        branch_inst,
    output logic        reg_reg_inst,
    output logic        ex_load_inst,
    output logic        ex_reg_dest,
    output logic [3:0]  alu_op,
    output logic        load_inst,
    output logic        reg_dest,
    output logic        illegal_inst,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {
        RUN = 2'd0,
        SQ1 = 2'd1,
        SQ2 = 2'd2
    } state_t;

    state_t state, state_next;

    logic       dec_branch, dec_reg_reg, dec_load, dec_reg_dest, dec_illegal;
    logic [3:0] dec_alu_op;
    logic       mem_valid, wb_valid;

    // Raw decode of the ID/EX instruction, independent of flush state.
    always_comb begin
        dec_branch   = 1'b0;
        dec_reg_reg  = 1'b0;
        dec_load     = 1'b0;
        dec_reg_dest = 1'b0;
        dec_illegal  = 1'b0;
        dec_alu_op   = 4'b0000;
        case (current_opcode)
            7'b0110011: begin
                dec_reg_reg = 1'b1;
                dec_alu_op  = current_func;
            end
            7'b0010011: begin
                // Only shift-right immediates carry a meaningful instr[30].
                if (current_func[2:0] == 3'b101)
                    dec_alu_op = current_func;
                else
                    dec_alu_op = {1'b0, current_func[2:0]};
            end
            7'b0000011: begin
                dec_load = 1'b1;
            end
            7'b0100011: begin
                dec_reg_dest = 1'b1;
                dec_load     = 1'b1;
            end
            7'b1100011: begin
                dec_branch  = 1'b1;
                dec_reg_reg = 1'b1;
                dec_alu_op  = 4'b1000;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Flush sequencer next state and EX gating. A taken branch in RUN is
    // honoured even under stall; stall only freezes the squash countdown.
    always_comb begin
        state_next   = state;
        branch_inst  = 1'b0;
        reg_reg_inst = 1'b0;
        ex_load_inst = 1'b0;
        ex_reg_dest  = 1'b0;
        alu_op       = 4'b0000;
        illegal_inst = 1'b0;
        case (state)
            RUN: begin
                branch_inst  = dec_branch;
                reg_reg_inst = dec_reg_reg;
                ex_load_inst = dec_load;
                ex_reg_dest  = dec_reg_dest;
                alu_op       = dec_alu_op;
                illegal_inst = dec_illegal;
                if (branch_taken)
                    state_next = SQ1;
            end
            SQ1: begin
                if (!stall)
                    state_next = SQ2;
            end
            SQ2: begin
                if (!stall)
                    state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            load_inst <= 1'b0;
            reg_dest  <= 1'b0;
            mem_valid <= 1'b0;
            wb_valid  <= 1'b0;
        end else begin
            state     <= state_next;
            load_inst <= stall ? 1'b0 : ex_load_inst;
            reg_dest  <= stall ? 1'b0 : ex_reg_dest;
            mem_valid <= !stall && (state == RUN) && !dec_illegal;
            wb_valid  <= mem_valid;
        end
    end

`ifdef PIPE_PERF_COUNTER_EN
    logic [31:0] perf_count;

    always_ff @(posedge clk) begin
        if (reset)
            perf_count <= 32'd0;
        else if (wb_valid)
            perf_count <= perf_count + 32'd1;
    end

    assign retired_count = perf_count;
`else
    logic unused_wb_valid;

    assign unused_wb_valid = wb_valid;
    assign retired_count   = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_control.sv
// tb/tb_pipe_control.sv - scoreboard bench for pipe_control
module tb_pipe_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  current_opcode;
    logic [3:0]  current_func;
    logic        branch_taken;
    logic        stall;
    logic        branch_inst, reg_reg_inst, ex_load_inst, ex_reg_dest;
    logic [3:0]  alu_op;
    logic        load_inst, reg_dest, illegal_inst;
    logic [31:0] retired_count;

    pipe_control dut (
        .clk            (clk),
        .reset          (reset),
        .current_opcode (current_opcode),
        .current_func   (current_func),
        .branch_taken   (branch_taken),
        .stall          (stall),
        .branch_inst    (branch_inst),
        .reg_reg_inst   (reg_reg_inst),
        .ex_load_inst   (ex_load_inst),
        .ex_reg_dest    (ex_reg_dest),
        .alu_op         (alu_op),
        .load_inst      (load_inst),
        .reg_dest       (reg_dest),
        .illegal_inst   (illegal_inst),
        .retired_count  (retired_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: 0=RUN 1=SQ1 2=SQ2
    int          m_state = 0;
    logic        m_mem_valid = 1'b0;
    logic        m_wb_valid = 1'b0;
    logic [31:0] m_count = 32'd0;
    logic [1:0]  sb[$];

    logic       e_br, e_rr, e_ld, e_rd, e_ill;
    logic [3:0] e_alu;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_count();
`ifdef PIPE_PERF_COUNTER_EN
        return m_count;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_ex(input logic [6:0] op, input logic [3:0] fn);
        e_br = 0; e_rr = 0; e_ld = 0; e_rd = 0; e_ill = 0; e_alu = 4'b0000;
        if (m_state == 0) begin
            if (op == 7'b0110011) begin
                e_rr = 1; e_alu = fn;
            end else if (op == 7'b0010011) begin
                e_alu = (fn[2:0] == 3'b101) ? fn : {1'b0, fn[2:0]};
            end else if (op == 7'b0000011) begin
                e_ld = 1;
            end else if (op == 7'b0100011) begin
                e_ld = 1; e_rd = 1;
            end else if (op == 7'b1100011) begin
                e_br = 1; e_rr = 1; e_alu = 4'b1000;
            end else begin
                e_ill = 1;
            end
        end
    endtask

    task automatic step(input string tag, input logic [6:0] op, input logic [3:0] fn,
                        input logic bt, input logic st, input logic rst);
        logic [1:0] got_mem;
        @(negedge clk);
        current_opcode = op;
        current_func   = fn;
        branch_taken   = bt;
        stall          = st;
        reset          = rst;
        #1;
        model_ex(op, fn);
        check({tag, ":branch_inst"},  branch_inst,  e_br);
        check({tag, ":reg_reg_inst"}, reg_reg_inst, e_rr);
        check({tag, ":ex_load_inst"}, ex_load_inst, e_ld);
        check({tag, ":ex_reg_dest"},  ex_reg_dest,  e_rd);
        check({tag, ":alu_op"},       alu_op,       e_alu);
        check({tag, ":illegal_inst"}, illegal_inst, e_ill);
        if (rst) begin
            sb.push_back(2'b00);
            m_state = 0; m_mem_valid = 0; m_wb_valid = 0; m_count = 0;
        end else begin
            sb.push_back(st ? 2'b00 : {e_ld, e_rd});
            if (m_wb_valid) m_count = m_count + 32'd1;
            m_wb_valid  = m_mem_valid;
            m_mem_valid = !st && (m_state == 0) && !e_ill;
            if (m_state == 0) begin
                if (bt) m_state = 1;
            end else if (!st) begin
                m_state = (m_state == 1) ? 2 : 0;
            end
        end
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ":sb_underflow"}, 32'd0, 32'd1);
        end else begin
            got_mem = sb.pop_front();
            check({tag, ":load_inst"}, load_inst, got_mem[1]);
            check({tag, ":reg_dest"},  reg_dest,  got_mem[0]);
        end
        check({tag, ":retired_count"}, retired_count, exp_count());
    endtask

    initial begin
        reset = 1; current_opcode = 7'b0110011; current_func = 4'b0000;
        branch_taken = 1; stall = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset:load_inst", load_inst, 1'b0);
        check("reset:reg_dest", reg_dest, 1'b0);
        check("reset:retired_count", retired_count, 32'd0);

        step("rtype",   7'b0110011, 4'b1000, 0, 0, 0);
        step("ialu_sr", 7'b0010011, 4'b1101, 0, 0, 0);
        step("ialu_ad", 7'b0010011, 4'b1010, 0, 0, 0);
        step("ialu_srl",7'b0010011, 4'b0101, 0, 0, 0);
        step("load",    7'b0000011, 4'b0010, 0, 0, 0);
        step("store",   7'b0100011, 4'b0010, 0, 0, 0);
        step("branch",  7'b1100011, 4'b0001, 0, 0, 0);
        step("illegal", 7'b1111111, 4'b1111, 0, 0, 0);
        step("after_il",7'b0110011, 4'b0000, 0, 0, 0);
        step("drain",   7'b0110011, 4'b0000, 0, 0, 0);

        // Branch flush with wrong-path branch_taken at N+1
        step("bt_n",    7'b0110011, 4'b0111, 1, 0, 0);
        step("bt_n1",   7'b0110011, 4'b0111, 1, 0, 0);
        step("bt_n2",   7'b0110011, 4'b0111, 0, 0, 0);
        step("bt_n3",   7'b0110011, 4'b0111, 0, 0, 0);

        // Stall + branch together, then stall holding squash
        step("st_bt",   7'b0000011, 4'b0000, 1, 1, 0);
        step("st_sq1",  7'b0000011, 4'b0000, 0, 1, 0);
        step("sq1",     7'b0000011, 4'b0000, 0, 0, 0);
        step("sq2",     7'b0000011, 4'b0000, 0, 0, 0);
        step("run_ld",  7'b0000011, 4'b0000, 0, 0, 0);

        // Reset in SQ1 with stall and branch_taken asserted
        step("pre_rst", 7'b0100011, 4'b0000, 1, 0, 0);
        step("rst_sq1", 7'b0100011, 4'b0000, 1, 1, 1);
        step("post_rst",7'b0100011, 4'b0000, 0, 0, 0);
        step("post_r2", 7'b0110011, 4'b0001, 0, 0, 0);
        step("post_r3", 7'b0110011, 4'b0001, 0, 0, 0);

`ifdef PIPE_PERF_COUNTER_EN
        // Preload counter to all ones; WB valid is 1 here (valid R-types in flight)
        @(negedge clk);
        force dut.perf_count = 32'hFFFF_FFFF;
        #1;
        release dut.perf_count;
        m_count = 32'hFFFF_FFFF;
        check("preload", retired_count, 32'hFFFF_FFFF);
        step("wrap",    7'b0110011, 4'b0001, 0, 0, 0);
`endif

        for (int i = 0; i < 60; i++) begin
            logic [6:0] op;
            case ($urandom_range(0, 5))
                0: op = 7'b0110011;
                1: op = 7'b0010011;
                2: op = 7'b0000011;
                3: op = 7'b0100011;
                4: op = 7'b1100011;
                default: op = 7'($urandom);
            endcase
            step("rand", op, 4'($urandom), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
